// File: rtl/uart_rx_line_assemble.sv
// Assembles UART RX bytes into fixed-width 34-char text lines (payload padded with spaces, then CR LF).
// Latency: line published one cycle after the LF strobe (o_line_valid pulse).
// Backpressure: none; consumer must sample outputs on the o_line_valid pulse.
//
// Ports:
//   i_clk_20mhz       system clock
//   i_rst_20mhz       asynchronous active-low reset
//   i_rx_data         received byte, qualified by i_rx_valid
//   i_rx_valid        one-cycle strobe for i_rx_data / i_rx_error
//   i_rx_error        framing error on the strobed byte
//   o_dat_ascii_line  last published line, first char in the top byte
//   o_line_valid      one-cycle pulse on a newly published line
//   o_line_len        payload character count of the published line
//   o_line_trunc      published line was truncated or hit a framing error
//   o_line_count      published line counter, wraps at 256
module uart_rx_line_assemble #(
  parameter int C_LINE_CHARS = 32
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rst_20mhz,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_error,
  output logic [(C_LINE_CHARS+2)*8-1:0] o_dat_ascii_line,
  output logic                          o_line_valid,
  output logic [5:0]                    o_line_len,
  output logic                          o_line_trunc,
  output logic [7:0]                    o_line_count
);

  localparam int              LP_BUF_W   = C_LINE_CHARS * 8;
  localparam logic [5:0]      LP_MAX_IDX = 6'(C_LINE_CHARS);
  localparam logic [7:0]      LP_SPACE   = 8'h20;
  localparam logic [7:0]      LP_CR      = 8'h0D;
  localparam logic [7:0]      LP_LF      = 8'h0A;
  localparam logic [LP_BUF_W-1:0] LP_BLANK = {C_LINE_CHARS{LP_SPACE}};

  typedef enum logic [1:0] {
    ST_RXLINE_IDLE,
    ST_RXLINE_DATA,
    ST_RXLINE_DISCARD
  } t_rxline_state;

  t_rxline_state                 r_state;
  logic [LP_BUF_W-1:0]           r_buf;
  logic [5:0]                    r_idx;
  logic [(C_LINE_CHARS+2)*8-1:0] r_line;
  logic                          r_line_valid;
  logic [5:0]                    r_line_len;
  logic                          r_line_trunc;
  logic [7:0]                    r_line_count;

  logic w_is_lf;
  logic w_is_cr;

  assign w_is_lf = (i_rx_data == LP_LF);
  assign w_is_cr = (i_rx_data == LP_CR);

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      r_state      <= ST_RXLINE_IDLE;
      r_buf        <= LP_BLANK;
      r_idx        <= '0;
      r_line       <= {LP_BLANK, LP_CR, LP_LF};
      r_line_valid <= 1'b0;
      r_line_len   <= '0;
      r_line_trunc <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_line_valid <= 1'b0;
      if (i_rx_valid) begin
        // A framing error takes priority over the byte value: even a corrupted
        // LF must not terminate the line.
        if (i_rx_error) begin
          r_state <= ST_RXLINE_DISCARD;
        end else if (w_is_lf) begin
          r_line       <= {r_buf, LP_CR, LP_LF};
          r_line_len   <= r_idx;
          r_line_trunc <= (r_state == ST_RXLINE_DISCARD);
          r_line_valid <= 1'b1;
          r_line_count <= r_line_count + 8'd1;
          r_buf        <= LP_BLANK;
          r_idx        <= '0;
          r_state      <= ST_RXLINE_IDLE;
        end else if (!w_is_cr && (r_state != ST_RXLINE_DISCARD)) begin
          if (r_idx < LP_MAX_IDX) begin
            // Slot 0 occupies the most significant byte of the buffer.
            for (int s = 0; s < C_LINE_CHARS; s++) begin
              if (r_idx == 6'(s)) begin
                r_buf[(C_LINE_CHARS-1-s)*8 +: 8] <= i_rx_data;
              end
            end
            r_idx   <= r_idx + 6'd1;
            r_state <= ST_RXLINE_DATA;
          end else begin
            // Buffer full: drop the rest of the line until LF.
            r_state <= ST_RXLINE_DISCARD;
          end
        end
      end
    end
  end

  assign o_dat_ascii_line = r_line;
  assign o_line_valid     = r_line_valid;
  assign o_line_len       = r_line_len;
  assign o_line_trunc     = r_line_trunc;
  assign o_line_count     = r_line_count;

endmodule
